// File: rtl/fpn_pkg.sv
// Shared helpers for the column FPN corrector: LUT lane slicing, unity gain, pixel bounds.
package fpn_pkg;

    // Lane i of a LUT word: gain at the lane base, offset directly above it.
    function automatic int lane_gain_lsb(input int lane, input int gain_bits, input int offset_bits);
        return lane * (gain_bits + offset_bits);
    endfunction

    function automatic int lane_off_lsb(input int lane, input int gain_bits, input int offset_bits);
        return lane * (gain_bits + offset_bits) + gain_bits;
    endfunction

    function automatic int unity_gain(input int gain_frac_bits);
        return 1 << gain_frac_bits;
    endfunction

    function automatic int pix_max(input int pixel_bits);
        return (1 << pixel_bits) - 1;
    endfunction

    localparam int PIX_MIN            = 0;
    localparam int DEFAULT_UNITY_GAIN = unity_gain(7);

endpackage

// File: rtl/fpn_lane_mac.sv
// One pixel lane: gain multiply with round-half-up, then signed offset add and clamp.
// With FPN_CLIP_STATS_EN defined, also emits a per-beat clip flag.
module fpn_lane_mac
    import fpn_pkg::*;
#(
    parameter int PIXEL_BITS     = 8,
    parameter int GAIN_BITS      = 8,
    parameter int GAIN_FRAC_BITS = 7,
    parameter int OFFSET_BITS    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic [PIXEL_BITS-1:0]         pix_p1,
    input  logic [GAIN_BITS-1:0]          gain_p1,
    input  logic signed [OFFSET_BITS-1:0] off_p1,
    input  logic                          byp_p1,
`ifdef FPN_CLIP_STATS_EN
    output logic                          clip_p3,
`endif
    output logic [PIXEL_BITS-1:0]         pix_p3
);

    localparam int PW  = PIXEL_BITS + GAIN_BITS;
    localparam int PW1 = PW + 1;
    localparam int RW  = PW1 - GAIN_FRAC_BITS;
    localparam int SW  = PW + 2;
    localparam logic [PW1-1:0]       HALF   = PW1'(1) << (GAIN_FRAC_BITS - 1);
    localparam logic signed [SW-1:0] SAT_HI = SW'(pix_max(PIXEL_BITS));

    function automatic logic [RW-1:0] round_gain(input logic [PIXEL_BITS-1:0] pix,
                                                 input logic [GAIN_BITS-1:0] gain);
        logic [PW1-1:0] p;
        p = PW1'(pix) * PW1'(gain) + HALF;
        return p[PW1-1:GAIN_FRAC_BITS];
    endfunction

    function automatic logic [PIXEL_BITS-1:0] sat_pix(input logic signed [SW-1:0] s);
        if (s < 0)
            return '0;
        else if (s > SAT_HI)
            return '1;
        else
            return s[PIXEL_BITS-1:0];
    endfunction

    logic [RW-1:0]                r_p2;
    logic signed [OFFSET_BITS-1:0] off_p2;
    logic [PIXEL_BITS-1:0]        pix_p2;
    logic                         byp_p2;
    logic signed [SW-1:0]         sum_p2;

    // S2: multiply and round
    always_ff @(posedge clk) begin
        if (ce) begin
            r_p2   <= round_gain(pix_p1, gain_p1);
            off_p2 <= off_p1;
            pix_p2 <= pix_p1;
            byp_p2 <= byp_p1;
        end
    end

    always_comb begin
        sum_p2 = signed'(SW'(r_p2)) + SW'(off_p2);
    end

    // S3: offset add and clamp
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pix_p3 <= '0;
        else if (ce)
            pix_p3 <= byp_p2 ? pix_p2 : sat_pix(sum_p2);
    end

`ifdef FPN_CLIP_STATS_EN
    always_ff @(posedge clk) begin
        if (ce)
            clip_p3 <= !byp_p2 && ((sum_p2 < 0) || (sum_p2 > SAT_HI));
    end
`endif

endmodule

// File: rtl/column_fpn_corrector.sv
// Per-column fixed-pattern-noise correction, N pixels per beat, 3-stage pipeline with backpressure.
// Optional FPN_CLIP_STATS_EN adds clip_count: clipped lanes in the previous frame.
module column_fpn_corrector
    import fpn_pkg::*;
#(
    parameter int PIXEL_BITS     = 8,
    parameter int N              = 4,
    parameter int GAIN_BITS      = 8,
    parameter int GAIN_FRAC_BITS = 7,
    parameter int OFFSET_BITS    = 8,
    parameter int WIDTH_BITS     = 10,
    parameter int LUT_DATA_BITS  = (GAIN_BITS + OFFSET_BITS) * N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PIXEL_BITS*N-1:0]    s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       s_eol,
    input  logic                       s_eof,
    output logic [PIXEL_BITS*N-1:0]    m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_eol,
    output logic                       m_eof,
    output logic [WIDTH_BITS-1:0]      lut_raddr,
    output logic                       lut_ren,
    input  logic [LUT_DATA_BITS-1:0]   lut_rdata,
    input  logic [WIDTH_BITS-1:0]      cfg_line_beats,
    input  logic                       cfg_bypass,
`ifdef FPN_CLIP_STATS_EN
    output logic                       err_line_len,
    output logic [2*WIDTH_BITS+3:0]    clip_count
`else
    output logic                       err_line_len
`endif
);

    logic                    ce;
    logic                    accept;
    logic [WIDTH_BITS-1:0]   col;
    logic                    frame_start;
    logic                    bypass_q;
    logic                    vld_p1, eol_p1, eof_p1;
    logic                    vld_p2, eol_p2, eof_p2;
    logic [PIXEL_BITS*N-1:0] data_p1;
    logic                    byp_p1;

    assign ce        = !m_valid || m_ready;
    assign s_ready   = ce;
    assign accept    = s_valid && ce;
    assign lut_ren   = ce;
    assign lut_raddr = col;

    // Column tracking, line-length check and frame-synchronous bypass latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col          <= '0;
            err_line_len <= 1'b0;
            frame_start  <= 1'b1;
            bypass_q     <= 1'b0;
        end else begin
            err_line_len <= 1'b0;
            if (accept) begin
                frame_start <= s_eof;
                if (frame_start)
                    bypass_q <= cfg_bypass;
                if (s_eol) begin
                    col          <= '0;
                    err_line_len <= (col != cfg_line_beats);
                end else if (col == cfg_line_beats) begin
                    col          <= '0;
                    err_line_len <= 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Valid-qualified sideband through S1..S3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0; eol_p1 <= 1'b0; eof_p1 <= 1'b0;
            vld_p2  <= 1'b0; eol_p2 <= 1'b0; eof_p2 <= 1'b0;
            m_valid <= 1'b0; m_eol  <= 1'b0; m_eof  <= 1'b0;
        end else if (ce) begin
            vld_p1  <= s_valid;
            eol_p1  <= s_valid && s_eol;
            eof_p1  <= s_valid && s_eof;
            vld_p2  <= vld_p1;
            eol_p2  <= eol_p1;
            eof_p2  <= eof_p1;
            m_valid <= vld_p2;
            m_eol   <= eol_p2;
            m_eof   <= eof_p2;
        end
    end

    // S1: pixel register, aligned with the LUT word read at acceptance
    always_ff @(posedge clk) begin
        if (ce) begin
            data_p1 <= s_data;
            byp_p1  <= frame_start ? cfg_bypass : bypass_q;
        end
    end

`ifdef FPN_CLIP_STATS_EN
    logic [N-1:0] clip_p3;
`endif

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int GL = lane_gain_lsb(i, GAIN_BITS, OFFSET_BITS);
        localparam int OL = lane_off_lsb(i, GAIN_BITS, OFFSET_BITS);
        fpn_lane_mac #(
            .PIXEL_BITS    (PIXEL_BITS),
            .GAIN_BITS     (GAIN_BITS),
            .GAIN_FRAC_BITS(GAIN_FRAC_BITS),
            .OFFSET_BITS   (OFFSET_BITS)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .ce     (ce),
            .pix_p1 (data_p1[i*PIXEL_BITS +: PIXEL_BITS]),
            .gain_p1(lut_rdata[GL +: GAIN_BITS]),
            .off_p1 (lut_rdata[OL +: OFFSET_BITS]),
            .byp_p1 (byp_p1),
`ifdef FPN_CLIP_STATS_EN
            .clip_p3(clip_p3[i]),
`endif
            .pix_p3 (m_data[i*PIXEL_BITS +: PIXEL_BITS])
        );
    end

`ifdef FPN_CLIP_STATS_EN
    localparam int CW  = 2 * WIDTH_BITS + 4;
    localparam int CW1 = CW + 1;

    logic [CW-1:0] clip_acc;
    logic [CW:0]   clip_sum;

    function automatic logic [CW-1:0] sat_count(input logic [CW:0] v);
        return v[CW] ? '1 : v[CW-1:0];
    endfunction

    always_comb begin
        clip_sum = {1'b0, clip_acc};
        for (int i = 0; i < N; i++)
            clip_sum = clip_sum + CW1'(clip_p3[i]);
    end

    // Frame total published on the eof handshake, including that beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_acc   <= '0;
            clip_count <= '0;
        end else if (m_valid && m_ready) begin
            if (m_eof) begin
                clip_count <= sat_count(clip_sum);
                clip_acc   <= '0;
            end else begin
                clip_acc <= sat_count(clip_sum);
            end
        end
    end
`endif

endmodule

// File: doc/column_fpn_corrector.md
Name: column_fpn_corrector

Overview:
- Successor to the column-level gain/offset stage in the sensor video path: per-column fixed-pattern-noise correction, N pixels per beat.
- Adds valid/ready backpressure, a signed offset with rounding and saturation, runtime line length with line-length error detection, and frame-synchronous bypass.
- Sits between the sensor deserialiser and the ISP.
- Reads per-column coefficients from an external synchronous LUT RAM with 1-cycle read latency.

Parameters:
- PIXEL_BITS, 8, bits per pixel.
- N, 4, pixels per beat.
- GAIN_BITS, 8, unsigned gain width.
- GAIN_FRAC_BITS, 7, gain fractional bits; 1<<GAIN_FRAC_BITS is unity gain.
- OFFSET_BITS, 8, two's-complement offset width.
- WIDTH_BITS, 10, column-beat index width.
- LUT_DATA_BITS, (GAIN_BITS+OFFSET_BITS)*N, LUT word width. Lane i holds gain at [i*(G+O)+:G] and offset directly above it.

Ports:
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- s_data, in, PIXEL_BITS*N, input pixels; lane 0 in the LSBs.
- s_valid, in, 1, input beat valid.
- s_ready, out, 1, block accepts a beat.
- s_eol, in, 1, last beat of line.
- s_eof, in, 1, last beat of frame; always coincides with s_eol.
- m_data, out, PIXEL_BITS*N, corrected pixels.
- m_valid, out, 1, output beat valid.
- m_ready, in, 1, downstream accepts.
- m_eol, out, 1, delayed s_eol.
- m_eof, out, 1, delayed s_eof.
- lut_raddr, out, WIDTH_BITS, LUT column address.
- lut_ren, out, 1, LUT read enable.
- lut_rdata, in, LUT_DATA_BITS, LUT data; valid 1 cycle after lut_ren.
- cfg_line_beats, in, WIDTH_BITS, beats per line minus 1; quasi-static.
- cfg_bypass, in, 1, bypass request.
- err_line_len, out, 1, one-cycle pulse on line-length mismatch.

Behaviour:
- Pipeline: 3 stages (S1 LUT fetch + data register, S2 multiply/round, S3 add/saturate). Single global advance enable ce = !m_valid || m_ready.
- s_ready = ce. A beat is accepted when s_valid && s_ready.
- Latency: 3 cycles input-to-output when not stalled. Full throughput of 1 beat per cycle.
- Stall: all stage registers and lut_raddr hold. lut_ren = ce, so the LUT output register also holds. No beat is lost or duplicated.
- Column counter col:
  - Addresses the LUT: lut_raddr = col of the beat being accepted.
  - On accepted s_eol, col returns to 0.
  - Otherwise col increments; at col == cfg_line_beats it wraps to 0.
- err_line_len pulses, on the cycle after acceptance, in either case:
  - s_eol accepted with col != cfg_line_beats (short line).
  - Wrap without s_eol (long line).
- Per lane:
  - Product p = pix*gain, width PIXEL_BITS+GAIN_BITS.
  - Rounding: r = (p + (1<<(GAIN_FRAC_BITS-1))) >> GAIN_FRAC_BITS.
  - Sum s = r + sign-extended offset, computed signed at width PIXEL_BITS+GAIN_BITS+2.
  - Clamp: s<0 gives 0; s>2^PIXEL_BITS-1 gives 2^PIXEL_BITS-1.
- Bypass:
  - cfg_bypass is latched into bypass_q on the first accepted beat of a frame (after reset, or after an accepted s_eof). A mid-frame change has no effect until the next frame.
  - When bypass_q is set, m_data equals s_data delayed by the same 3 stages. LUT reads continue.
- Reset: m_valid=0, m_eol=0, m_eof=0, m_data=0, col=0, lut_raddr=0, err_line_len=0, bypass_q=0, frame-start flag=1. s_ready=1 after reset. Reset mid-line discards in-flight beats.
- Sideband (eol/eof/valid) is carried in valid-qualified stage registers. Data-path registers need no reset, except m_data, which resets to 0.

Optional Feature:
- Macro FPN_CLIP_STATS_EN.
- When defined:
  - Adds output clip_count, 2*WIDTH_BITS+4 bits: saturated lanes (low or high, non-bypass) in the previous frame.
  - Internal accumulator adds the per-beat popcount of clip flags on output handshake.
  - On output handshake with m_eof, the accumulator total including that beat is copied to clip_count and the accumulator clears. The register does not wrap; it saturates at all-ones.
  - clip_count resets to 0.
- When undefined: the port and logic are absent. The behaviour above is unchanged.

Decomposition:
- Package fpn_pkg: lane slice-offset helper functions, unity-gain constant, saturation bounds.
- One sub-module, fpn_lane_mac: per-lane 2-stage multiply/round/add/saturate with clock enable, emitting data and a clip flag. Instantiated N times by generate.

Test Plan:
- Unity gain 128, offset 0, cfg_line_beats=3, 4-beat lines -> m_data == s_data after 3 cycles. s_ready stays 1. m_eol on beat 3.
- Gain 192 (1.5), offset -10, pix 100 -> 140. Pix 200, offset +100 -> 255 (clip). Gain 64, offset -60, pix 50 -> 0 (clip).
- Random m_ready deasserted 50% with varying per-column LUT -> output sequence identical to a scoreboard model. No drops. lut_raddr correct per column.
- Line with s_eol on beat 2 when cfg_line_beats=3 -> err_line_len single pulse. Next line's col starts at 0. Line of 6 beats without eol -> pulse at wrap.
- cfg_bypass toggled mid-frame -> takes effect only from the first beat after m_eof/s_eof. Output equals input in the bypass frame.
- Assert rst mid-line with 2 beats in flight -> m_valid=0 next cycle. Post-reset line corrected from column 0. With FPN_CLIP_STATS_EN, clip_count=0.
